// File: rtl/uvme_st_echo_pkg.sv
// Shared types and limits for the self-test stream echo responder.
package uvme_st_echo_pkg;

  localparam int unsigned MIN_DEPTH   = 32'd2;
  localparam int unsigned MIN_MAX_LEN = 32'd1;

  // Input-side frame tracking states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DROP     = 2'd2
  } in_state_e;

  // Storage cost of one beat (data plus end-of-frame flag).
  function automatic int unsigned beat_bits(input int unsigned data_w);
    return data_w + 32'd1;
  endfunction

endpackage

// File: rtl/uvme_st_echo_fifo.sv
// First-word-fall-through FIFO of beats; the head is valid whenever the FIFO is non-empty.
module uvme_st_echo_fifo #(
  parameter type beat_t = logic [32:0],
  parameter int  DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  beat_t                  wr_beat,
  input  logic                   pop,
  output beat_t                  head,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt,
  output logic                   full,
  output logic                   empty
);
  import uvme_st_echo_pkg::*;

  localparam int PTR_W = (DEPTH < MIN_DEPTH) ? 1 : $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  beat_t             mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (level_r == FULL_LVL);
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];
  assign level     = level_r;
  assign level_nxt = level_nxt_s;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Beat storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_beat;
    end
  end

  // Pointers wrap naturally at DEPTH; level disambiguates full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_nxt_s;
    end
  end

endmodule

// File: rtl/uvme_st_echo_rsp.sv
// Stream echo responder: buffers TX beats and replays them on RX, cutting
// frames longer than MAX_LEN and counting frames that leave on the RX side.
module uvme_st_echo_rsp #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   trunc_err,
  output logic [$clog2(DEPTH):0] level
);
  import uvme_st_echo_pkg::*;

  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int BCNT_W = $clog2(MAX_LEN + 1);
  localparam int BEAT_W = beat_bits(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  in_state_e          state_r;
  in_state_e          state_nxt;
  logic [BCNT_W-1:0]  bcnt_r;
  logic [BCNT_W-1:0]  bcnt_nxt;
  logic               in_ready_r;
  logic               trunc_err_r;
  logic [CNT_W-1:0]   frame_cnt_r;

  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic               trunc_s;
  beat_t              wr_beat_s;
  beat_t              head_s;
  logic [LVL_W-1:0]   level_s;
  logic [LVL_W-1:0]   level_nxt_s;
  logic               full_s;
  logic               empty_s;

  assign accept_s = in_valid && in_ready_r;
  assign pop_s    = !empty_s && out_ready;

  uvme_st_echo_fifo #(
    .beat_t (beat_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s && !full_s),
    .wr_beat   (wr_beat_s),
    .pop       (pop_s),
    .head      (head_s),
    .level     (level_s),
    .level_nxt (level_nxt_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Frame tracking: decides whether an accepted beat is stored, cut short or dropped.
  always_comb begin
    state_nxt = state_r;
    bcnt_nxt  = bcnt_r;
    push_s    = 1'b0;
    trunc_s   = 1'b0;
    wr_beat_s = '{data: in_data, last: in_last};
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          push_s = 1'b1;
          if (in_last) begin
            state_nxt = IDLE;
            bcnt_nxt  = {BCNT_W{1'b0}};
          end else if (MAX_LEN == 1) begin
            wr_beat_s.last = 1'b1;
            trunc_s        = 1'b1;
            state_nxt      = DROP;
            bcnt_nxt       = {BCNT_W{1'b0}};
          end else begin
            state_nxt = IN_FRAME;
            bcnt_nxt  = BCNT_W'(1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      IN_FRAME: begin
        if (accept_s) begin
          push_s = 1'b1;
          if (in_last) begin
            state_nxt = IDLE;
            bcnt_nxt  = {BCNT_W{1'b0}};
          end else if (bcnt_r == BCNT_W'(MAX_LEN - 1)) begin
            wr_beat_s.last = 1'b1;
            trunc_s        = 1'b1;
            state_nxt      = DROP;
            bcnt_nxt       = {BCNT_W{1'b0}};
          end else begin
            state_nxt = IN_FRAME;
            bcnt_nxt  = bcnt_r + BCNT_W'(1);
          end
        end else begin
          state_nxt = IN_FRAME;
        end
      end
      DROP: begin
        if (accept_s && in_last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DROP;
        end
      end
      default: begin
        state_nxt = IDLE;
        bcnt_nxt  = {BCNT_W{1'b0}};
      end
    endcase
  end

  // in_ready is registered from next-cycle occupancy, so it stays low through
  // reset and never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      bcnt_r      <= {BCNT_W{1'b0}};
      in_ready_r  <= 1'b0;
      trunc_err_r <= 1'b0;
      frame_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt;
      bcnt_r      <= bcnt_nxt;
      in_ready_r  <= (state_nxt == DROP) || (level_nxt_s < LVL_W'(DEPTH));
      trunc_err_r <= trunc_s;
      if (pop_s && head_s.last) begin
        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign trunc_err = trunc_err_r;
  assign frame_cnt = frame_cnt_r;
  assign level     = level_s;
  assign out_valid = !empty_s;
  assign out_data  = empty_s ? {DATA_W{1'b0}} : head_s.data;
  assign out_last  = !empty_s && head_s.last;

  logic [BEAT_W-1:0] unused_head_s;
  assign unused_head_s = head_s;

endmodule

// File: tb/tb_uvme_st_echo_rsp.sv
// Directed bench for uvme_st_echo_rsp with an in-bench queue model of the echo path.
module tb_uvme_st_echo_rsp;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [CNT_W-1:0]  frame_cnt;
  logic              trunc_err;
  logic [3:0]        level;

  int errors = 0;
  int checks = 0;
  int trunc_seen = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } mbeat_t;

  mbeat_t q[$];
  int     m_cnt = 0;
  bit     m_drop = 1'b0;
  int     m_fc = 0;
  bit     m_trunc = 1'b0;
  bit     m_rdy = 1'b0;
  bit     m_tr;

  uvme_st_echo_rsp #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_cnt (frame_cnt),
    .trunc_err (trunc_err),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frames of at most MAX_LEN beats go into an ordered queue; extra beats vanish.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        m_cnt = 0; m_drop = 1'b0; m_fc = 0; m_trunc = 1'b0; m_rdy = 1'b0;
      end else begin
        m_tr = 1'b0;
        if (out_ready && q.size() != 0) begin
          if (q[0].l) m_fc = (m_fc + 1) % (1 << CNT_W);
          void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          if (m_drop) begin
            if (in_last) m_drop = 1'b0;
          end else begin
            m_cnt++;
            if (in_last) begin
              q.push_back('{in_data, 1'b1});
              m_cnt = 0;
            end else if (m_cnt == MAX_LEN) begin
              q.push_back('{in_data, 1'b1});
              m_tr = 1'b1; m_drop = 1'b1; m_cnt = 0;
            end else begin
              q.push_back('{in_data, 1'b0});
            end
          end
        end
        m_trunc = m_tr;
        m_rdy   = m_drop || (q.size() < DEPTH);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (trunc_err === 1'b1) trunc_seen++;
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("level", 32'(level), 32'(q.size()));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("trunc_err", 32'(trunc_err), 32'(m_trunc));
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_last", 32'(out_last), 32'(q[0].l));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l, output int edges);
    bit rdy;
    bit acc;
    in_valid = 1'b1; in_data = d; in_last = l;
    edges = 0; acc = 1'b0;
    while (!acc && edges < 200) begin
      rdy = in_ready;
      @(posedge clk); #1;
      edges++;
      acc = rdy;
    end
    chk("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int e;
    int total;
    int t0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Single beat with one-cycle fall-through
    out_ready = 1'b1;
    send(32'hA5A5_0001, 1'b1, e);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'hA5A5_0001);
    chk("single_last", 32'(out_last), 32'd1);
    chk("single_fc_before", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    chk("single_fc_after", 32'(frame_cnt), 32'd1);
    chk("single_drained", 32'(out_valid), 32'd0);

    // Backpressure fill: 8 fit, the 9th waits for the first pop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 1'b0, e);
    chk("fill_level", 32'(level), 32'd8);
    in_valid = 1'b1; in_data = 32'h108; in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd8);
    out_ready = 1'b1;
    send(32'h108, 1'b1, e);
    chk("ninth_accept_edges", 32'(e), 32'd2);
    wait_empty();
    chk("fill_fc", 32'(frame_cnt), 32'd2);

    // Full-rate streaming: 10 frames of 10 beats with no input stalls
    total = 0;
    for (int f = 0; f < 10; f++) begin
      for (int b = 0; b < 10; b++) begin
        send(32'(f * 256 + b), (b == 9), e);
        total += e;
      end
    end
    chk("stream_edges", 32'(total), 32'd100);
    wait_empty();
    chk("stream_fc", 32'(frame_cnt), 32'd12);

    // Truncation of a 20-beat frame, then an intact 3-beat frame
    t0 = trunc_seen;
    for (int i = 0; i < 20; i++) send(32'h2000 + 32'(i), (i == 19), e);
    for (int i = 0; i < 3; i++) send(32'h3000 + 32'(i), (i == 2), e);
    wait_empty();
    chk("trunc_pulses", 32'(trunc_seen - t0), 32'd1);
    chk("trunc_fc", 32'(frame_cnt), 32'd14);

    // Reset in the middle of a buffered frame
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h4000 + 32'(i), 1'b0, e);
    chk("mid_level", 32'(level), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Counter wrap: 17 single-beat frames on a 4-bit counter
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(32'h5000 + 32'(i), 1'b1, e);
    wait_empty();
    chk("wrap_fc", 32'(frame_cnt), 32'd1);
    for (int i = 0; i < 3; i++) send(32'h6000 + 32'(i), (i == 2), e);
    wait_empty();
    chk("post_reset_frame_fc", 32'(frame_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
